sdram_req_arbiter: RTL and testbench

//  Shares the single SDRAM controller command port between the video fetcher, the
//  CPU and an internal refresh scheduler. It sits between the system bus masters
//  and the SDRAM controller that drives sdram_*. One transaction is outstanding at
//  a time; the arbiter sequences request, issue and completion for each one.

---
 rtl/sdram_req_arbiter.sv | 85 ++++++++
 tb/tb_sdram_req_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter: shares one SDRAM command port between video, CPU and refresh,
// one outstanding transaction at a time with urgent-refresh and video-run limits.
module sdram_req_arbiter #(
  parameter int ADDR_W       = 24,
  parameter int REF_INTERVAL = 390,
  parameter int REF_MAX      = 4,
  parameter int VID_RUN_MAX  = 4
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_done,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic              mem_valid,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic              mem_done,
  output logic [2:0]        ref_debt
);
  localparam int TW = $clog2(REF_INTERVAL);
  localparam int RW = $clog2(VID_RUN_MAX + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] WAIT  = 2'd3;
  logic [1:0]        state, cmd_q, own;
  logic [ADDR_W-1:0] addr_q;
  logic [TW-1:0]     timer;
  logic [RW-1:0]     run;
  logic [2:0]        debt, debt_nxt;
  logic              idle, tick, urgent, vid_win, sel_ref, sel_vid, sel_cpu, sel;
  always_comb begin
    idle     = state == IDLE;
    tick     = timer == '0;
    urgent   = debt == 3'(REF_MAX);
    vid_win  = vid_req && !(run == RW'(VID_RUN_MAX) && cpu_req);
    sel_ref  = idle && (urgent || (!vid_win && !cpu_req && debt != 3'd0));
    sel_vid  = idle && !urgent && vid_win;
    sel_cpu  = idle && !urgent && !vid_win && cpu_req;
    sel      = sel_ref || sel_vid || sel_cpu;
    // a tick and a refresh in the same cycle cancel out
    debt_nxt = (tick == sel_ref) ? debt : tick ? (urgent ? debt : debt + 3'd1) : debt - 3'd1;
  end
  assign mem_valid = state == ISSUE;
  assign mem_cmd   = mem_valid ? cmd_q : 2'b00;
  assign mem_addr  = mem_valid ? addr_q : '0;
  assign ref_debt  = debt;
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= TW'(REF_INTERVAL - 1);
      debt     <= '0;
      run      <= '0;
      own      <= '0;
      cmd_q    <= '0;
      addr_q   <= '0;
      vid_gnt  <= 1'b0;
      cpu_gnt  <= 1'b0;
      vid_done <= 1'b0;
      cpu_done <= 1'b0;
    end else begin
      timer    <= tick ? TW'(REF_INTERVAL - 1) : timer - TW'(1);
      debt     <= debt_nxt;
      run      <= (!cpu_req || sel_cpu) ? '0 : (sel_vid && run != RW'(VID_RUN_MAX)) ? run + RW'(1) : run;
      vid_gnt  <= sel_vid;
      cpu_gnt  <= sel_cpu;
      vid_done <= state == WAIT && mem_done && own[0];
      cpu_done <= state == WAIT && mem_done && own[1];
      state    <= sel ? GRANT : (state == GRANT) ? ISSUE : (state == ISSUE && mem_ready) ? WAIT :
                  (state == WAIT && mem_done) ? IDLE : state;
      if (sel) begin
        own    <= {sel_cpu, sel_vid};
        cmd_q  <= sel_ref ? 2'b11 : (sel_cpu && cpu_we) ? 2'b10 : 2'b01;
        addr_q <= sel_vid ? vid_addr : sel_cpu ? cpu_addr : '0;
      end
    end
  end
endmodule

// File: tb/tb_sdram_req_arbiter.sv
// tb_sdram_req_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model of the arbiter.
module tb_sdram_req_arbiter;
  logic        clk_sys = 1'b0, rst_n = 1'b0;
  logic        vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, mem_ready = 1'b0, mem_done = 1'b0;
  logic [23:0] vid_addr = '0, cpu_addr = '0, mem_addr;
  logic        vid_gnt, vid_done, cpu_gnt, cpu_done, mem_valid;
  logic [1:0]  mem_cmd;
  logic [2:0]  ref_debt;
  int          tests = 0, fails = 0;
  int          m_cyc = 0, m_phase = 0, m_owner = 0, m_run = 0, m_win = 0;
  logic        m_tick = 1'b0, m_vgnt = 1'b0, m_cgnt = 1'b0, m_vdone = 1'b0, m_cdone = 1'b0;
  logic [2:0]  m_debt = '0;
  logic [1:0]  m_cmd = '0;
  logic [23:0] m_addr = '0;
  logic [33:0] got, exp;

  always #5 clk_sys = ~clk_sys;

  sdram_req_arbiter dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt), .vid_done(vid_done),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
    .mem_valid(mem_valid), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_done(mem_done), .ref_debt(ref_debt)
  );

  // reference model: phase 0 idle, 1 granted, 2 command offered, 3 awaiting completion
  always @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0; m_phase = 0; m_owner = 0; m_run = 0; m_win = 0; m_debt = '0; m_cmd = '0; m_addr = '0;
      m_vgnt = 1'b0; m_cgnt = 1'b0; m_vdone = 1'b0; m_cdone = 1'b0;
    end else begin
      m_tick = (m_cyc % 390) == 389;
      m_cyc++;
      m_win = 0;
      m_vgnt = 1'b0; m_cgnt = 1'b0; m_vdone = 1'b0; m_cdone = 1'b0;
      case (m_phase)
        0: begin
          if (m_debt == 3'd4) m_win = 3;
          else if (vid_req && !(m_run == 4 && cpu_req)) m_win = 1;
          else if (cpu_req) m_win = 2;
          else if (m_debt != 3'd0) m_win = 3;
          if (m_win != 0) begin
            m_owner = m_win;
            m_phase = 1;
            m_cmd   = (m_win == 3) ? 2'b11 : (m_win == 2 && cpu_we) ? 2'b10 : 2'b01;
            m_addr  = (m_win == 1) ? vid_addr : (m_win == 2) ? cpu_addr : 24'h0;
          end
          m_vgnt = m_win == 1;
          m_cgnt = m_win == 2;
        end
        1: m_phase = 2;
        2: if (mem_ready) m_phase = 3;
        default: if (mem_done) begin
          m_vdone = m_owner == 1;
          m_cdone = m_owner == 2;
          m_phase = 0;
        end
      endcase
      if (!cpu_req || m_win == 2) m_run = 0;
      else if (m_win == 1) m_run = (m_run < 4) ? m_run + 1 : 4;
      if (m_tick && m_win != 3) m_debt = (m_debt == 3'd4) ? 3'd4 : m_debt + 3'd1;
      else if (!m_tick && m_win == 3) m_debt = m_debt - 3'd1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0; vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; mem_ready = 1'b0; mem_done = 1'b0;
    vid_addr = '0; cpu_addr = '0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cyc(2);
    tests++;
    if ({vid_gnt, vid_done, cpu_gnt, cpu_done, mem_valid, mem_cmd, mem_addr, ref_debt} !== 34'h0)
      begin fails++; $display("FAIL reset_outputs: got %h want 0", {vid_gnt, vid_done, cpu_gnt, cpu_done, mem_valid, mem_cmd, mem_addr, ref_debt}); end
    rst_n = 1'b1;
    cyc(389);
    tests++;
    if (ref_debt !== 3'd0) begin fails++; $display("FAIL debt_before_tick: got %0d want 0", ref_debt); end
    cyc(1);
    tests++;
    if (ref_debt !== 3'd1) begin fails++; $display("FAIL debt_after_tick: got %0d want 1", ref_debt); end
    cyc(1);
    tests++;
    if (ref_debt !== 3'd0) begin fails++; $display("FAIL debt_after_refresh_sel: got %0d want 0", ref_debt); end
    cyc(1);
    tests++;
    if (mem_valid !== 1'b1 || mem_cmd !== 2'b11 || mem_addr !== 24'h0)
      begin fails++; $display("FAIL idle_refresh_cmd: got v=%0b cmd=%b addr=%h want v=1 cmd=11 addr=0", mem_valid, mem_cmd, mem_addr); end
    mem_ready = 1'b1;
    cyc(1);
    mem_ready = 1'b0; mem_done = 1'b1;
    cyc(1);
    mem_done = 1'b0;
    tests++;
    if ({mem_valid, vid_done, cpu_done} !== 3'b000)
      begin fails++; $display("FAIL refresh_no_done: got %b want 000", {mem_valid, vid_done, cpu_done}); end
  endtask

  task automatic test_cpu_write;
    do_reset();
    mem_ready = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'h001234;
    cyc(1);
    tests++;
    if (cpu_gnt !== 1'b1 || mem_valid !== 1'b0) begin fails++; $display("FAIL cpu_gnt_latency: got gnt=%0b v=%0b want gnt=1 v=0", cpu_gnt, mem_valid); end
    cpu_req = 1'b0;
    cyc(1);
    tests++;
    if (mem_valid !== 1'b1 || mem_cmd !== 2'b10 || mem_addr !== 24'h001234 || cpu_gnt !== 1'b0)
      begin fails++; $display("FAIL cpu_issue: got v=%0b cmd=%b addr=%h gnt=%0b want 1 10 001234 0", mem_valid, mem_cmd, mem_addr, cpu_gnt); end
    cyc(1);
    tests++;
    if (mem_valid !== 1'b0) begin fails++; $display("FAIL valid_drop_after_accept: got %0b want 0", mem_valid); end
    mem_ready = 1'b0;
    cyc(2);
    mem_done = 1'b1;
    cyc(1);
    mem_done = 1'b0;
    tests++;
    if (cpu_done !== 1'b1 || vid_done !== 1'b0) begin fails++; $display("FAIL cpu_done_pulse: got c=%0b v=%0b want c=1 v=0", cpu_done, vid_done); end
    cyc(1);
    tests++;
    if (cpu_done !== 1'b0) begin fails++; $display("FAIL cpu_done_width: got %0b want 0", cpu_done); end
  endtask

  task automatic test_vid_cpu_fairness;
    int n = 0, ncpu = 0;
    logic want_cpu;
    do_reset();
    mem_ready = 1'b1; mem_done = 1'b1; vid_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
    vid_addr = 24'($urandom); cpu_addr = 24'($urandom);
    for (int c = 0; c < 300 && n < 10; c++) begin
      cyc(1);
      if (vid_gnt === 1'b1 || cpu_gnt === 1'b1) begin
        want_cpu = (n % 5) == 4;
        tests++;
        if (cpu_gnt !== want_cpu || vid_gnt !== !want_cpu)
          begin fails++; $display("FAIL grant_order[%0d]: got v=%0b c=%0b want c=%0b", n, vid_gnt, cpu_gnt, want_cpu); end
        if (cpu_gnt === 1'b1) ncpu++;
        n++;
      end
    end
    tests++;
    if (n != 10) begin fails++; $display("FAIL grant_timeout: got %0d grants want 10", n); end
    tests++;
    if (ncpu != 2) begin fails++; $display("FAIL cpu_share: got %0d cpu grants want 2", ncpu); end
    vid_req = 1'b0; cpu_req = 1'b0; mem_done = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_urgent_refresh;
    logic [23:0] a;
    a = 24'($urandom);
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    cyc(1);
    cpu_req = 1'b0;
    cyc(1600);
    tests++;
    if (ref_debt !== 3'd4 || mem_valid !== 1'b1 || mem_cmd !== 2'b01 || mem_addr !== a)
      begin fails++; $display("FAIL debt_saturate_hold: got d=%0d v=%0b cmd=%b addr=%h want 4 1 01 %h", ref_debt, mem_valid, mem_cmd, mem_addr, a); end
    vid_req = 1'b1; vid_addr = 24'($urandom); mem_ready = 1'b1;
    cyc(1);
    mem_ready = 1'b0; mem_done = 1'b1;
    cyc(1);
    mem_done = 1'b0;
    tests++;
    if (cpu_done !== 1'b1) begin fails++; $display("FAIL urgent_cpu_done: got %0b want 1", cpu_done); end
    cyc(1);
    tests++;
    if (vid_gnt !== 1'b0 || ref_debt !== 3'd3) begin fails++; $display("FAIL urgent_first: got vgnt=%0b d=%0d want 0 3", vid_gnt, ref_debt); end
    cyc(1);
    tests++;
    if (mem_valid !== 1'b1 || mem_cmd !== 2'b11 || mem_addr !== 24'h0)
      begin fails++; $display("FAIL urgent_cmd: got v=%0b cmd=%b addr=%h want 1 11 0", mem_valid, mem_cmd, mem_addr); end
    mem_ready = 1'b1;
    cyc(1);
    mem_ready = 1'b0; mem_done = 1'b1;
    cyc(1);
    mem_done = 1'b0;
    cyc(1);
    tests++;
    if (vid_gnt !== 1'b1) begin fails++; $display("FAIL vid_after_urgent: got %0b want 1", vid_gnt); end
    vid_req = 1'b0;
  endtask

  task automatic test_tick_coincide;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 24'($urandom);
    cyc(1);
    cpu_req = 1'b0;
    cyc(1166);
    mem_ready = 1'b1;
    cyc(1);
    mem_ready = 1'b0; mem_done = 1'b1;
    cyc(1);
    mem_done = 1'b0;
    tests++;
    if (ref_debt !== 3'd2) begin fails++; $display("FAIL debt_before_coincide: got %0d want 2", ref_debt); end
    cyc(1);
    tests++;
    if (ref_debt !== 3'd2) begin fails++; $display("FAIL debt_on_coincide: got %0d want 2", ref_debt); end
    cyc(1);
    tests++;
    if (mem_valid !== 1'b1 || mem_cmd !== 2'b11) begin fails++; $display("FAIL coincide_refresh: got v=%0b cmd=%b want 1 11", mem_valid, mem_cmd); end
  endtask

  task automatic test_async_reset;
    do_reset();
    cpu_req = 1'b1; cpu_addr = 24'($urandom);
    cyc(1);
    cpu_req = 1'b0;
    cyc(1);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({mem_valid, mem_cmd, mem_addr} !== 27'h0) begin fails++; $display("FAIL reset_in_issue: got v=%0b cmd=%b addr=%h want 0", mem_valid, mem_cmd, mem_addr); end
    cyc(1);
    rst_n = 1'b1; mem_ready = 1'b1; cpu_req = 1'b1;
    cyc(1);
    cpu_req = 1'b0;
    cyc(2);
    #2 rst_n = 1'b0; mem_done = 1'b1;
    #1;
    tests++;
    if ({vid_gnt, vid_done, cpu_gnt, cpu_done, mem_valid, ref_debt} !== 8'h0)
      begin fails++; $display("FAIL reset_in_wait: got %b want 0", {vid_gnt, vid_done, cpu_gnt, cpu_done, mem_valid, ref_debt}); end
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    mem_done = 1'b0;
    tests++;
    if (cpu_done !== 1'b0) begin fails++; $display("FAIL no_done_after_reset: got %0b want 0", cpu_done); end
    cpu_req = 1'b1; cpu_we = 1'b0;
    cyc(1);
    cpu_req = 1'b0;
    tests++;
    if (cpu_gnt !== 1'b1) begin fails++; $display("FAIL gnt_after_reset: got %0b want 1", cpu_gnt); end
  endtask

  task automatic test_random;
    int nbad = 0;
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      if (!vid_req || m_vgnt) begin vid_req = 1'($urandom % 2); vid_addr = 24'($urandom); end
      if (!cpu_req || m_cgnt) begin cpu_req = 1'($urandom % 2); cpu_we = 1'($urandom % 2); cpu_addr = 24'($urandom); end
      mem_ready = ((i % 3000) >= 1000 && (i % 3000) < 2600) ? 1'b0 : 1'($urandom % 3 != 0);
      mem_done = 1'($urandom % 3 == 0);
      cyc(1);
      got = {vid_gnt, cpu_gnt, vid_done, cpu_done, mem_valid, mem_cmd, mem_addr, ref_debt};
      exp = {m_vgnt, m_cgnt, m_vdone, m_cdone, m_phase == 2, (m_phase == 2) ? m_cmd : 2'b00,
             (m_phase == 2) ? m_addr : 24'h0, m_debt};
      tests++;
      if (got !== exp) begin
        fails++;
        nbad++;
        if (nbad <= 10) $display("FAIL random_cycle[%0d]: got %h want %h", i, got, exp);
      end
    end
    vid_req = 1'b0; cpu_req = 1'b0; mem_ready = 1'b0; mem_done = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cpu_write();
    test_vid_cpu_fairness();
    test_urgent_refresh();
    test_tick_coincide();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
